// File: rtl/picorv32_ahb_pkg.sv
// ----------------------------------------------------------------------------
// picorv32_ahb_pkg
// Shared constants for the PicoRV32-to-AHB-Lite bridge: AHB transfer type,
// size, burst and response encodings, plus the bridge FSM state type.
// No ports (package).
// ----------------------------------------------------------------------------
package picorv32_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } ahb_state_t;

endpackage

// File: rtl/ahb_size_decode.sv
// ----------------------------------------------------------------------------
// ahb_size_decode
// Combinational decode of PicoRV32 byte strobes into AHB transfer size,
// the low two address bits and the transfer direction.
// Ports:
//   mem_wstrb  in  4   byte strobes (0000 = read)
//   addr_lo    in  2   CPU address bits [1:0]
//   hsize      out 3   AHB transfer size
//   haddr_lo   out 2   AHB address bits [1:0]
//   hwrite     out 1   transfer is a write
//   illegal    out 1   strobe pattern has no AHB size; issued as a word write
// ----------------------------------------------------------------------------
module ahb_size_decode
    import picorv32_ahb_pkg::*;
(
    input  logic [3:0] mem_wstrb,
    input  logic [1:0] addr_lo,
    output logic [2:0] hsize,
    output logic [1:0] haddr_lo,
    output logic       hwrite,
    output logic       illegal
);

    // Writes are lane-aligned by the CPU, so the strobes alone locate the
    // bytes. Reads always fetch the whole aligned word, so the CPU's low
    // address bits are masked off rather than forwarded.
    always_comb begin
        hsize    = HSIZE_WORD;
        haddr_lo = 2'b00;
        hwrite   = 1'b1;
        illegal  = 1'b0;
        case (mem_wstrb)
            4'b0000: begin
                hwrite   = 1'b0;
                haddr_lo = addr_lo & 2'b00;
            end
            4'b1111: hsize = HSIZE_WORD;
            4'b0011: hsize = HSIZE_HALF;
            4'b1100: begin
                hsize    = HSIZE_HALF;
                haddr_lo = 2'b10;
            end
            4'b0001: hsize = HSIZE_BYTE;
            4'b0010: begin
                hsize    = HSIZE_BYTE;
                haddr_lo = 2'b01;
            end
            4'b0100: begin
                hsize    = HSIZE_BYTE;
                haddr_lo = 2'b10;
            end
            4'b1000: begin
                hsize    = HSIZE_BYTE;
                haddr_lo = 2'b11;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/picorv32_ahb_master.sv
// ----------------------------------------------------------------------------
// picorv32_ahb_master
// Bridge from the PicoRV32 native memory interface to a single-master
// AHB-Lite bus. Each mem_valid request becomes one SINGLE NONSEQ transfer;
// transfers are strictly sequential (no address/data overlap).
// Ports:
//   hclk, hresetn                 clock, async active-low reset
//   mem_valid/instr/addr/wdata/wstrb   CPU request
//   mem_ready, mem_rdata, bus_err      CPU completion (one-cycle pulse)
//   haddr, htrans, hwrite, hsize, hburst, hprot, hwdata   AHB master outputs
//   hrdata, hready, hresp               AHB slave response
// ----------------------------------------------------------------------------
module picorv32_ahb_master
    import picorv32_ahb_pkg::*;
#(
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    ahb_state_t  state;
    logic        illegal_q;

    logic [2:0]  dec_hsize;
    logic [1:0]  dec_addr_lo;
    logic        dec_hwrite;
    logic        dec_illegal;

    ahb_size_decode u_size_decode (
        .mem_wstrb (mem_wstrb),
        .addr_lo   (mem_addr[1:0]),
        .hsize     (dec_hsize),
        .haddr_lo  (dec_addr_lo),
        .hwrite    (dec_hwrite),
        .illegal   (dec_illegal)
    );

    assign hburst = HBURST_SINGLE;

    // All AHB and CPU-side outputs are registered here. The request is
    // captured once in IDLE, so address/control stay frozen through any
    // number of ADDR or DATA wait states. hwdata is only reloaded for writes,
    // which leaves it holding its previous value across reads.
    // RESP never samples mem_valid: the detour through IDLE gives the CPU a
    // cycle to drop mem_valid so a finished request is not issued twice.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            htrans    <= HTRANS_IDLE;
            haddr     <= 32'h0;
            hwrite    <= 1'b0;
            hsize     <= HSIZE_WORD;
            hprot     <= 4'h0;
            hwdata    <= 32'h0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            bus_err   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_valid) begin
                        haddr     <= {mem_addr[31:2], dec_addr_lo};
                        hsize     <= dec_hsize;
                        hwrite    <= dec_hwrite;
                        hprot     <= {2'b00, 1'b1, ~mem_instr};
                        illegal_q <= dec_illegal;
                        if (dec_hwrite) begin
                            hwdata <= mem_wdata;
                        end
                        htrans    <= HTRANS_NONSEQ;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // The first ERROR cycle arrives with hready low and is
                    // simply another wait cycle; completion is hready high.
                    if (hready) begin
                        if (hresp == HRESP_ERROR && !hwrite) begin
                            mem_rdata <= ERR_RDATA;
                        end else begin
                            mem_rdata <= hrdata;
                        end
                        mem_ready <= 1'b1;
                        bus_err   <= (hresp != HRESP_OKAY) || illegal_q;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    mem_ready <= 1'b0;
                    bus_err   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_ahb_master.sv
// ----------------------------------------------------------------------------
// tb_picorv32_ahb_master
// Self-checking bench for picorv32_ahb_master. A small AHB slave with a
// word-addressed memory model is driven cycle by cycle from do_req; expected
// CPU-side completions are queued when a request is issued and popped when
// mem_ready appears.
// ----------------------------------------------------------------------------
module tb_picorv32_ahb_master;

    logic        hclk;
    logic        hresetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    typedef struct {
        logic [31:0] rdata;
        bit          is_read;
        bit          err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_model [logic [29:0]];
    int          tests_run;
    int          tests_failed;
    int          cyc_count;
    int          last_nonseq;
    logic [31:0] last_hwdata;

    picorv32_ahb_master #(.ERR_RDATA(32'hDEAD_BEEF)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    always @(posedge hclk) cyc_count++;

    // Slave-side byte-lane merge for sub-word writes
    function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                                input logic [31:0] d,
                                                input logic [2:0]  sz,
                                                input logic [1:0]  lo);
        logic [3:0]  m;
        logic [31:0] r;
        case (sz)
            3'd0:    m = 4'b0001 << lo;
            3'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Issue one CPU request and play the slave for it. Called and returns
    // at #1 after a rising edge.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr,
                          input int aw, input int dw, input bit err,
                          input logic [31:0] exp_haddr, input logic [2:0] exp_hsize,
                          input bit exp_err);
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          acnt;
        int          dcnt;
        int          phase;
        bit          err_first;
        bit          done;
        logic [41:0] act_ctl;
        logic [41:0] exp_ctl;
        logic [31:0] exp_wd;
        e.is_read = (wstrb == 4'b0000);
        e.err     = exp_err;
        e.lat     = 3 + aw + dw + (err ? 1 : 0);
        if (err && e.is_read)
            e.rdata = 32'hDEAD_BEEF;
        else if (mem_model.exists(exp_haddr[31:2]))
            e.rdata = mem_model[exp_haddr[31:2]];
        else
            e.rdata = 32'h0;
        sb.push_back(e);
        exp_ctl = {2'b10, exp_haddr, exp_hsize, ~e.is_read, 2'b00, 1'b1, ~instr};
        exp_wd  = e.is_read ? last_hwdata : wdata;

        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        hready    = 1'b1;
        hresp     = 1'b0;
        cyc = 0; acnt = 0; dcnt = 0; phase = 0; err_first = 0; done = 0;
        while (!done) begin
            @(posedge hclk); #1;
            cyc++;
            if (cyc > 60) begin
                tests_run++; tests_failed++;
                $display("[TB] FAIL timeout: no completion after %0d cycles, required %0d", cyc, e.lat);
                if (sb.size() > 0) got = sb.pop_front();
                mem_valid = 1'b0;
                break;
            end
            case (phase)
                0: begin
                    if (acnt == 0) last_nonseq = cyc_count;
                    act_ctl = {htrans, haddr, hsize, hwrite, hprot};
                    tests_run++;
                    if (act_ctl !== exp_ctl) begin
                        tests_failed++;
                        $display("[TB] FAIL addr_ctl: got %h required %h (cycle %0d)", act_ctl, exp_ctl, cyc);
                    end
                    tests_run++;
                    if (mem_ready !== 1'b0) begin
                        tests_failed++;
                        $display("[TB] FAIL early_ready_addr: got %b required 0", mem_ready);
                    end
                    if (acnt < aw) begin
                        hready = 1'b0;
                        acnt++;
                    end else begin
                        hready = 1'b1;
                        phase  = 1;
                    end
                end
                1: begin
                    tests_run++;
                    if ({htrans, hwdata, mem_ready} !== {2'b00, exp_wd, 1'b0}) begin
                        tests_failed++;
                        $display("[TB] FAIL data_phase: htrans/hwdata/ready got %b/%h/%b required 00/%h/0",
                                 htrans, hwdata, mem_ready, exp_wd);
                    end
                    if (dcnt < dw) begin
                        hready = 1'b0;
                        hresp  = 1'b0;
                        hrdata = $urandom();
                        dcnt++;
                    end else if (err && !err_first) begin
                        hready    = 1'b0;
                        hresp     = 1'b1;
                        hrdata    = $urandom();
                        err_first = 1'b1;
                    end else begin
                        hready = 1'b1;
                        hresp  = err;
                        if (!hwrite)
                            hrdata = mem_model.exists(haddr[31:2]) ? mem_model[haddr[31:2]] : 32'h0;
                        else
                            hrdata = $urandom();
                        if (hwrite && !err) begin
                            mem_model[haddr[31:2]] = merge_lanes(
                                mem_model.exists(haddr[31:2]) ? mem_model[haddr[31:2]] : 32'h0,
                                hwdata, hsize, haddr[1:0]);
                        end
                        phase = 2;
                    end
                end
                2: begin
                    tests_run++;
                    if (mem_ready !== 1'b1) begin
                        tests_failed++;
                        $display("[TB] FAIL mem_ready: got %b required 1 at cycle %0d", mem_ready, cyc);
                        if (sb.size() > 0) got = sb.pop_front();
                    end else begin
                        got = sb.pop_front();
                        if (got.is_read) begin
                            tests_run++;
                            if (mem_rdata !== got.rdata) begin
                                tests_failed++;
                                $display("[TB] FAIL mem_rdata: got %h required %h", mem_rdata, got.rdata);
                            end
                        end
                        tests_run++;
                        if (bus_err !== got.err) begin
                            tests_failed++;
                            $display("[TB] FAIL bus_err: got %b required %b", bus_err, got.err);
                        end
                        tests_run++;
                        if (cyc !== got.lat) begin
                            tests_failed++;
                            $display("[TB] FAIL latency: got %0d required %0d", cyc, got.lat);
                        end
                    end
                    mem_valid = 1'b0;
                    hready    = 1'b1;
                    hresp     = 1'b0;
                    phase     = 3;
                end
                default: begin
                    tests_run++;
                    if ({mem_ready, bus_err, htrans} !== 4'b0000) begin
                        tests_failed++;
                        $display("[TB] FAIL pulse_end: ready/err/htrans got %b%b%b required 0000",
                                 mem_ready, bus_err, htrans);
                    end
                    done = 1'b1;
                end
            endcase
        end
        if (!e.is_read) last_hwdata = wdata;
    endtask

    // Reset values and hburst constant
    task automatic test_reset();
        hresetn = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        tests_run++;
        if ({hburst, htrans, haddr, hwrite, hsize, hprot, hwdata, mem_ready, mem_rdata, bus_err} !==
            {3'b000, 2'b00, 32'h0, 1'b0, 3'd2, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got htrans=%b haddr=%h hwrite=%b hsize=%0d hprot=%b hwdata=%h ready=%b rdata=%h err=%b hburst=%b",
                     htrans, haddr, hwrite, hsize, hprot, hwdata, mem_ready, mem_rdata, bus_err, hburst);
        end
        hresetn = 1'b1;
        @(posedge hclk); #1;
        tests_run++;
        if ({htrans, mem_ready} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got %b%b required 000", htrans, mem_ready);
        end
    endtask

    task automatic test_word_write();
        do_req(32'h8000_0004, 32'h1234_5678, 4'b1111, 1'b0, 0, 0, 0, 32'h8000_0004, 3'd2, 0);
    endtask

    task automatic test_read();
        do_req(32'h8000_0004, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h8000_0004, 3'd2, 0);
        tests_run++;
        if (mem_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("[TB] FAIL read_back: got %h required 12345678", mem_rdata);
        end
        do_req(32'h8000_0004, 32'h0, 4'b0000, 1'b1, 0, 0, 0, 32'h8000_0004, 3'd2, 0);
        do_req(32'h8000_0007, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h8000_0004, 3'd2, 0);
    endtask

    task automatic test_byte_half();
        logic [3:0]  strb [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b0011};
        logic [31:0] dat  [6] = '{32'h0000_0011, 32'h0000_2200, 32'h00AB_0000,
                                  32'h4400_0000, 32'hCDEF_0000, 32'h0000_5566};
        logic [31:0] ea   [6] = '{32'h8000_0000, 32'h8000_0001, 32'h8000_0002,
                                  32'h8000_0003, 32'h8000_0002, 32'h8000_0000};
        logic [2:0]  es   [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
        for (int i = 0; i < 6; i++) begin
            do_req(32'h8000_0000, dat[i], strb[i], 1'b0, 0, 0, 0, ea[i], es[i], 0);
            if (i == 3) begin
                do_req(32'h8000_0000, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h8000_0000, 3'd2, 0);
                tests_run++;
                if (mem_rdata !== 32'h44AB_2211) begin
                    tests_failed++;
                    $display("[TB] FAIL byte_merge: got %h required 44ab2211", mem_rdata);
                end
            end
        end
        do_req(32'h8000_0000, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h8000_0000, 3'd2, 0);
        tests_run++;
        if (mem_rdata !== 32'hCDEF_5566) begin
            tests_failed++;
            $display("[TB] FAIL half_merge: got %h required cdef5566", mem_rdata);
        end
    endtask

    task automatic test_wait_states();
        do_req(32'h8000_0008, 32'hA5A5_5A5A, 4'b1111, 1'b0, 2, 3, 0, 32'h8000_0008, 3'd2, 0);
        do_req(32'h8000_0008, 32'h0, 4'b0000, 1'b1, 1, 1, 0, 32'h8000_0008, 3'd2, 0);
    endtask

    task automatic test_error();
        do_req(32'h8000_000C, 32'h0, 4'b0000, 1'b0, 0, 0, 1, 32'h8000_000C, 3'd2, 1);
        tests_run++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("[TB] FAIL err_rdata_hold: got %h required deadbeef", mem_rdata);
        end
        do_req(32'h8000_0004, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h8000_0004, 3'd2, 0);
        do_req(32'h8000_0014, 32'h0BAD_F00D, 4'b1111, 1'b0, 0, 2, 1, 32'h8000_0014, 3'd2, 1);
    endtask

    task automatic test_illegal_strobe();
        do_req(32'h8000_0011, 32'h7654_3210, 4'b0101, 1'b0, 0, 0, 0, 32'h8000_0010, 3'd2, 1);
        do_req(32'h8000_0010, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h8000_0010, 3'd2, 0);
        tests_run++;
        if (mem_rdata !== 32'h7654_3210) begin
            tests_failed++;
            $display("[TB] FAIL illegal_as_word: got %h required 76543210", mem_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_req(32'h8000_0020, 32'h1111_2222, 4'b1111, 1'b0, 0, 0, 0, 32'h8000_0020, 3'd2, 0);
        t0 = last_nonseq;
        do_req(32'h8000_0020, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h8000_0020, 3'd2, 0);
        tests_run++;
        if (last_nonseq - t0 !== 4) begin
            tests_failed++;
            $display("[TB] FAIL nonseq_spacing: got %0d required 4", last_nonseq - t0);
        end
    endtask

    task automatic test_reset_in_data();
        mem_valid = 1'b1;
        mem_instr = 1'b0;
        mem_addr  = 32'h8000_0004;
        mem_wdata = 32'hFFFF_0000;
        mem_wstrb = 4'b1111;
        hready    = 1'b1;
        hresp     = 1'b0;
        @(posedge hclk); #1;
        tests_run++;
        if (htrans !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL rst_pre_addr: htrans got %b required 10", htrans);
        end
        @(posedge hclk); #1;
        hready = 1'b0;
        #2;
        hresetn = 1'b0;
        #1;
        tests_run++;
        if ({htrans, haddr, hwrite, hsize, hprot, hwdata, mem_ready, mem_rdata, bus_err} !==
            {2'b00, 32'h0, 1'b0, 3'd2, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got htrans=%b haddr=%h hwrite=%b hsize=%0d hprot=%b hwdata=%h ready=%b rdata=%h err=%b",
                     htrans, haddr, hwrite, hsize, hprot, hwdata, mem_ready, mem_rdata, bus_err);
        end
        mem_valid   = 1'b0;
        hready      = 1'b1;
        last_hwdata = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge hclk); #1;
            if (i == 2) hresetn = 1'b1;
            tests_run++;
            if ({mem_ready, htrans} !== 3'b000) begin
                tests_failed++;
                $display("[TB] FAIL abandoned_xfer: ready/htrans got %b%b required 000", mem_ready, htrans);
            end
        end
        do_req(32'h8000_0004, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 32'h8000_0004, 3'd2, 0);
        tests_run++;
        if (mem_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("[TB] FAIL read_after_reset: got %h required 12345678", mem_rdata);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc_count    = 0;
        last_nonseq  = 0;
        last_hwdata  = 32'h0;
        hresetn      = 1'b0;
        mem_valid    = 1'b0;
        mem_instr    = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_wstrb    = 4'h0;
        hrdata       = 32'h0;
        hready       = 1'b1;
        hresp        = 1'b0;

        test_reset();
        test_word_write();
        test_read();
        test_byte_half();
        test_wait_states();
        test_error();
        test_illegal_strobe();
        test_back_to_back();
        test_reset_in_data();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/picorv32_ahb_master.md
# picorv32_ahb_master

Bridge from the PicoRV32 native memory interface to a single-master AHB-Lite bus. It sits between the CPU core and the AHB slaves, such as the register block at 0x8000_0000. It converts each `mem_valid` request into one non-burst NONSEQ transfer and returns the data phase result through `mem_ready`/`mem_rdata`. Transfers are strictly one at a time, with no address/data pipelining across requests.

## Interface
- `ERR_RDATA`, default 32'hDEAD_BEEF: value returned on `mem_rdata` when a read completes with ERROR.
- `hclk`  in  1  clock.
- `hresetn`  in  1  reset; asynchronous, active-low.
- `mem_valid`  in  1  CPU request; held until `mem_ready`.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data, lane-aligned.
- `mem_wstrb`  in  4  byte strobes; 0 means read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data; valid while `mem_ready`=1.
- `bus_err`  out  1  one-cycle pulse, coincident with `mem_ready`, on ERROR response.
- `haddr`  out  32  AHB address.
- `htrans`  out  2  IDLE=00 or NONSEQ=10 only.
- `hwrite`  out  1  write.
- `hsize`  out  3  0=byte, 1=half, 2=word.
- `hburst`  out  3  constant 000 (SINGLE).
- `hprot`  out  4  {2'b00, 1'b1, ~mem_instr}.
- `hwdata`  out  32  write data, driven in data phase.
- `hrdata`  in  32  read data.
- `hready`  in  1  transfer done / bus ready.
- `hresp`  in  1  0=OKAY, 1=ERROR.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - `htrans`=00.
  - On `mem_valid`, register the request fields and go to ADDR.
- **ADDR**
  - `htrans`=10; `haddr`/`hwrite`/`hsize`/`hprot` come from registered values.
  - Held unchanged until `hready`=1 is sampled at a clock edge, then go to DATA.
- **DATA**
  - `htrans`=00; `hwdata` = registered `mem_wdata`, held stable for the whole data phase.
  - On `hready`=1, capture `hrdata` (or ERR_RDATA if `hresp`=1 on a read) and go to RESP.
  - ERROR handling: the first ERROR cycle has `hready`=0 and is ignored. Completion is the second cycle, with `hready`=1 and `hresp`=1. The first ERROR cycle does not start a new transfer.
- **RESP**
  - `mem_ready`=1 for exactly one cycle; `bus_err`=1 if ERROR was latched.
  - Always returns to IDLE. This lets PicoRV32 drop `mem_valid` before a new request is sampled.
- Size decode, from `mem_wstrb`:
  - 0000: read, hsize=2, haddr={addr[31:2],2'b00}.
  - 1111: hsize=2, low bits 00.
  - 0011 / 1100: hsize=1, haddr[1:0]=00 / 10.
  - 0001 / 0010 / 0100 / 1000: hsize=0, haddr[1:0]=00 / 01 / 10 / 11.
  - Any other pattern: treated as a word write (hsize=2) with `bus_err` pulsed at completion.
- Reads never drive `hwdata`; it holds its previous value.
- Reset (any state, any time): FSM to IDLE; `htrans`=00, `haddr`=0, `hwrite`=0, `hsize`=2, `hprot`=0, `hwdata`=0, `mem_ready`=0, `mem_rdata`=0, `bus_err`=0.
  - A transfer in flight is abandoned; no `mem_ready` is ever produced for it.
- `mem_valid` falling before `mem_ready` is illegal CPU behaviour; the bridge completes the AHB transfer regardless.

## Timing
- All outputs are registered or pure decodes of state plus registered fields; no combinational path from AHB inputs to AHB outputs.
- Zero-wait-state slave:
  - `mem_valid` sampled at edge 0.
  - NONSEQ visible in cycle 1.
  - Data phase in cycle 2.
  - `mem_ready` in cycle 3.
  - Latency: 3 cycles.
- Each slave wait state (`hready`=0 in DATA) adds one cycle.
- Each `hready`=0 cycle while in ADDR adds one cycle; address/control stay stable.
- Minimum spacing between consecutive NONSEQ transfers: 4 cycles (RESP→IDLE→ADDR).
- `mem_rdata` holds its value after `mem_ready` until the next capture.

## Structure
- Package `picorv32_ahb_pkg` holds:
  - HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD, HBURST_SINGLE, HRESP_OKAY/ERROR constants.
  - FSM state encoding.
- Sub-module `ahb_size_decode`: combinational; `mem_wstrb`, `mem_addr[1:0]` → `hsize`, `haddr[1:0]`, `hwrite`, `illegal`.

## Test plan
- Write 0x1234_5678 to 0x8000_0004 with wstrb 1111, zero-wait slave → NONSEQ haddr=0x8000_0004, hsize=2, hwrite=1, `hwdata`=0x1234_5678 in data phase, `mem_ready` 3 cycles after `mem_valid`.
- Read 0x8000_0004 after the write → `mem_rdata`=0x1234_5678; `hprot`=0011 for data, 0010 when `mem_instr`=1.
- Byte write, wstrb 0100, addr 0x8000_0000 → haddr=0x8000_0002, hsize=0; half write, wstrb 1100 → haddr low bits 10, hsize=1.
- Slave inserts 2 wait states in ADDR and 3 in DATA → address/control and `hwdata` stable throughout; `mem_ready` at cycle 8.
- Two-cycle ERROR response on read → `mem_rdata`=0xDEAD_BEEF, `bus_err` and `mem_ready` pulse together for 1 cycle; next request proceeds normally.
- `hresetn` asserted during DATA → all outputs reach reset values immediately; no `mem_ready`; after release, a new read completes correctly.
